// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types for the generic handshaked pipeline stage buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating event counter used for stage performance statistics.
// Compiled only when PIPE_STAGE_PERF_EN is defined, matching its single use site.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`endif

// File: rtl/pipe_stage_buffer.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, flush and stall.
// Optional saturating stall/flush counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter bit          FLUSH_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       r_state;
  pipe_state_t       w_next_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_accept;
  logic              w_pop;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_clear;

  // in_ready depends only on registered state and stall, never on out_ready.
  assign in_ready  = rst_n & ~stall & (r_state != FULL);
  assign out_valid = ~stall & (r_state != EMPTY);
  assign out_data  = r_main;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear          = 1'b0;
    if (flush) begin
      w_next_state = EMPTY;
      w_clear      = FLUSH_ZERO;
    end else if (!stall) begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_next_state   = BUSY;
          end
        end
        BUSY: begin
          if (w_accept && !w_pop) begin
            w_load_skid  = 1'b1;
            w_next_state = FULL;
          end else if (w_pop && !w_accept) begin
            w_next_state = EMPTY;
          end else if (w_pop && w_accept) begin
            w_load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_load_main_skid = 1'b1;
            w_next_state     = BUSY;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (w_clear) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  always_comb begin
    case (r_state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer (DATA_W=32, FLUSH_ZERO=1, CNT_W=4).
module tb_pipe_stage_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_buffer #(
    .DATA_W     (32),
    .FLUSH_ZERO (1'b1),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", {out_valid, in_ready, occupancy}, 4'b0000);
    end
    checks++;
    if ({out_data, stall_cnt, flush_cnt} !== 40'h0) begin
      errors++; $display("FAIL reset_data got %h exp %h", {out_data, stall_cnt, flush_cnt}, 40'h0);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release got %b exp %b", {in_ready, out_valid}, 2'b10);
    end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, vals[i]}) begin
        errors++; $display("FAIL stream_out[%0d] got %h exp %h", i,
                           {out_valid, occupancy, out_data}, {1'b1, 2'd1, vals[i]});
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 32'h33333333}) begin
      errors++; $display("FAIL stream_drain got %h exp %h",
                         {out_valid, occupancy, out_data}, {1'b0, 2'd0, 32'h33333333});
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    checks++;
    if ({occupancy, in_ready, out_valid, out_data} !== {2'd2, 1'b0, 1'b1, 32'hA}) begin
      errors++; $display("FAIL bp_full got %h exp %h",
                         {occupancy, in_ready, out_valid, out_data}, {2'd2, 1'b0, 1'b1, 32'hA});
    end
    in_data = 'x;
    tick();
    checks++;
    if ({occupancy, out_data} !== {2'd2, 32'hA}) begin
      errors++; $display("FAIL bp_hold got %h exp %h", {occupancy, out_data}, {2'd2, 32'hA});
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    checks++;
    if ({occupancy, out_valid, out_data} !== {2'd1, 1'b1, 32'hB}) begin
      errors++; $display("FAIL bp_pop_b got %h exp %h", {occupancy, out_valid, out_data}, {2'd1, 1'b1, 32'hB});
    end
    tick();
    checks++;
    if ({occupancy, out_valid} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL bp_empty got %b exp %b", {occupancy, out_valid}, 3'b000);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC;
    tick();
    in_data = 32'hD;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hEEEE; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({occupancy, out_valid, out_data} !== {2'd0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL flush_clear got %h exp %h", {occupancy, out_valid, out_data}, 35'h0);
    end
    tick();
    checks++;
    if ({occupancy, out_valid, out_data} !== {2'd0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL flush_no_emit got %h exp %h", {occupancy, out_valid, out_data}, 35'h0);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (flush_cnt !== 4'd1) begin
      errors++; $display("FAIL flush_cnt_one got %0d exp 1", flush_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b0, 2'd1, 32'hDEAD}) begin
        errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i,
                           {out_valid, in_ready, occupancy, out_data}, {1'b0, 1'b0, 2'd1, 32'hDEAD});
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 32'hDEAD}) begin
      errors++; $display("FAIL stall_resume got %h exp %h", {out_valid, out_data}, {1'b1, 32'hDEAD});
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt);
    end
`endif
    tick();
    checks++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++; $display("FAIL stall_popped got %b exp 000", {out_valid, occupancy});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234;
    tick();
    in_data = 32'h5678;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, occupancy, out_data} !== 36'h0) begin
      errors++; $display("FAIL async_reset got %h exp %h", {out_valid, in_ready, occupancy, out_data}, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, occupancy} !== 4'b1000) begin
      errors++; $display("FAIL async_release got %b exp 1000", {in_ready, out_valid, occupancy});
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
`ifdef PIPE_STAGE_PERF_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd0;
`endif
    do_reset();
    flush = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (flush_cnt !== exp_cnt) begin
      errors++; $display("FAIL sat_flush got %0d exp %0d", flush_cnt, exp_cnt);
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({flush_cnt, stall_cnt} !== {exp_cnt, 4'd0}) begin
      errors++; $display("FAIL sat_hold got %h exp %h", {flush_cnt, stall_cnt}, {exp_cnt, 4'd0});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_stall();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
